// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline types: the fetch entry record and default widths.
package pipeline_pkg;
  localparam int DATA_WIDTH_DEF  = 64;
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_DEF       = 4;

  // Fields are sized at the default widths; narrower instances zero-extend into them.
  typedef struct packed {
    logic [INSTR_WIDTH_DEF-1:0] instr;
    logic [DATA_WIDTH_DEF-1:0]  pc;
    logic [DATA_WIDTH_DEF-1:0]  pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side push and decode-side pop handshakes of the fetch buffer.
interface fetch_buffer_if
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
);
  logic                       i_valid;
  logic                       o_ready;
  logic [INSTR_WIDTH-1:0]     i_instr;
  logic [DATA_WIDTH-1:0]      i_pc;
  logic [DATA_WIDTH-1:0]      i_pc_plus4;
  logic                       o_valid;
  logic                       i_ready;
  logic [INSTR_WIDTH-1:0]     o_instr;
  logic [DATA_WIDTH-1:0]      o_pc;
  logic [DATA_WIDTH-1:0]      o_pc_plus4;
  logic [$clog2(DEPTH+1)-1:0] o_count;

  modport slave (
    input  i_valid, i_instr, i_pc, i_pc_plus4, i_ready,
    output o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_count
  );

  modport master (
    output i_valid, i_instr, i_pc, i_pc_plus4, i_ready,
    input  o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_count
  );
endinterface

// File: rtl/fetch_buffer.sv
// First-word-fall-through fetch buffer between fetch and decode; flush empties it
// synchronously, and an empty head reads as an all-zero bubble.
module fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic          i_clk,
  input  logic          i_arstn,
  input  logic          i_flush,
  fetch_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   head;
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           rdy_en;
  logic           full, push, pop;

  assign full = (count == CW'(DEPTH));
  // rdy_en keeps ready low through reset and for the edge that releases it
  assign bus.o_ready = rdy_en & ~full;
  assign bus.o_valid = (count != '0);
  assign bus.o_count = count;

  assign push = bus.i_valid & bus.o_ready & ~i_flush;
  assign pop  = bus.o_valid & bus.i_ready & ~i_flush;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (i_flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is never reset or cleared; the output gate hides stale contents.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wptr] <= '{instr:    INSTR_WIDTH_DEF'(bus.i_instr),
                     pc:       DATA_WIDTH_DEF'(bus.i_pc),
                     pc_plus4: DATA_WIDTH_DEF'(bus.i_pc_plus4)};
  end

  assign head           = mem[rptr];
  assign bus.o_instr    = bus.o_valid ? INSTR_WIDTH'(head.instr)   : '0;
  assign bus.o_pc       = bus.o_valid ? DATA_WIDTH'(head.pc)       : '0;
  assign bus.o_pc_plus4 = bus.o_valid ? DATA_WIDTH'(head.pc_plus4) : '0;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed checks of the fetch buffer followed by a randomized scoreboard run.
module tb_fetch_buffer;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic i_clk = 1'b0;
  logic i_arstn;
  logic i_flush;
  int   total = 0;
  int   bad = 0;
  logic [DW-1:0] exp_q[$];

  fetch_buffer_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

  fetch_buffer #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_arstn (i_arstn),
    .i_flush (i_flush),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [DW-1:0] pc);
    bus.i_valid    = v;
    bus.i_ready    = r;
    bus.i_pc       = pc;
    bus.i_pc_plus4 = pc + 64'd4;
    bus.i_instr    = 32'h1000_0000 | 32'(pc);
  endtask

  initial begin
    logic [DW-1:0] pc_n;
    logic v, r, pu, po;
    i_arstn = 1'b0;
    i_flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    #3;
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_pc",    64'(bus.o_pc),    64'd0);
    #9 i_arstn = 1'b1;
    #1;
    chk("ready_before_edge", 64'(bus.o_ready), 64'd0);
    tick();
    chk("ready_after_edge", 64'(bus.o_ready), 64'd1);

    // fill with pc 0,4,8,C while decode stalls
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 64'(4*i));
      tick();
      if (i == 0) begin
        chk("latency_valid", 64'(bus.o_valid), 64'd1);
        chk("latency_pc",    bus.o_pc,         64'h0);
      end
    end
    chk("full_count", 64'(bus.o_count), 64'd4);
    chk("full_ready", 64'(bus.o_ready), 64'd0);
    chk("full_pc",    bus.o_pc,         64'h0);
    chk("full_pc4",   bus.o_pc_plus4,   64'h4);
    chk("full_instr", 64'(bus.o_instr), 64'h1000_0000);
    drive(1'b1, 1'b0, 64'h10);
    tick();
    chk("stall_count", 64'(bus.o_count), 64'd4);
    chk("stall_pc",    bus.o_pc,         64'h0);

    // full: pop happens, push rejected
    drive(1'b1, 1'b1, 64'h10);
    tick();
    chk("fullpop_count", 64'(bus.o_count), 64'd3);
    chk("fullpop_pc",    bus.o_pc,         64'h4);
    drive(1'b0, 1'b1, '0);
    tick();
    chk("pop_count", 64'(bus.o_count), 64'd2);
    chk("pop_pc",    bus.o_pc,         64'h8);

    // steady push+pop at count 2; pointers wrap several times
    exp_q = '{64'h8, 64'hC};
    for (int k = 0; k < 10; k++) begin
      pc_n = 64'h100 + 64'(4*k);
      drive(1'b1, 1'b1, pc_n);
      tick();
      exp_q.push_back(pc_n);
      void'(exp_q.pop_front());
      chk("pp_count", 64'(bus.o_count), 64'd2);
      chk("pp_pc",    bus.o_pc,         exp_q[0]);
      chk("pp_pc4",   bus.o_pc_plus4,   exp_q[0] + 64'd4);
    end

    // count 3, then flush beats simultaneous push and pop
    drive(1'b1, 1'b0, 64'h200);
    tick();
    chk("pre_flush_count", 64'(bus.o_count), 64'd3);
    drive(1'b1, 1'b1, 64'h204);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    chk("flush_count", 64'(bus.o_count), 64'd0);
    chk("flush_valid", 64'(bus.o_valid), 64'd0);
    chk("flush_instr", 64'(bus.o_instr), 64'd0);
    chk("flush_pc",    bus.o_pc,         64'd0);
    chk("flush_ready", 64'(bus.o_ready), 64'd1);

    // async reset mid-stream at count 2
    drive(1'b1, 1'b0, 64'h300);
    tick();
    drive(1'b1, 1'b0, 64'h304);
    tick();
    drive(1'b0, 1'b0, '0);
    chk("pre_arst_count", 64'(bus.o_count), 64'd2);
    chk("pre_arst_pc",    bus.o_pc,         64'h300);
    #1 i_arstn = 1'b0;
    #1;
    chk("arst_count", 64'(bus.o_count), 64'd0);
    chk("arst_valid", 64'(bus.o_valid), 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd0);
    chk("arst_pc",    bus.o_pc,         64'd0);
    tick();
    #2 i_arstn = 1'b1;
    #1;
    chk("arst_rel_ready_pre", 64'(bus.o_ready), 64'd0);
    tick();
    chk("arst_rel_ready", 64'(bus.o_ready), 64'd1);
    chk("arst_rel_count", 64'(bus.o_count), 64'd0);

    // random traffic against a queue scoreboard
    exp_q.delete();
    pc_n = 64'h1000;
    for (int c = 0; c < 3000; c++) begin
      v  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      pu = v && (exp_q.size() < DEPTH);
      po = r && (exp_q.size() > 0);
      drive(v, r, pc_n);
      tick();
      if (po) void'(exp_q.pop_front());
      if (pu) begin
        exp_q.push_back(pc_n);
        pc_n = pc_n + 64'd4;
      end
      chk("rnd_count", 64'(bus.o_count), 64'(exp_q.size()));
      chk("rnd_ready", 64'(bus.o_ready), 64'(exp_q.size() < DEPTH));
      chk("rnd_pc",    bus.o_pc,         (exp_q.size() > 0) ? exp_q[0] : 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
